spi_memory_burst: RTL and testbench
===================================

// Module: spi_memory_burst
// PURPOSE
//  SPI-slave (mode 0) front end onto an on-chip register-file memory, generalising spiMemory.
//  Parametrised address/data width.
//  Supports burst transfers: address auto-increments per word while cs_pin stays low.
//  Drives miso_oe so the pin can be tri-stated at the top level.
//  Flags aborted frames. All SPI pins are oversampled on clk.
// PARAMETERS
//  ADDR_W   7              address bits; memory depth = 2**ADDR_W words
//  DATA_W   8              bits per data word
//  LED_W    4              width of leds debug output (LED_W <= DATA_W)
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  reset_n    in   1       asynchronous active-low reset
//  sclk_pin   in   1       SPI clock, async to clk; idle low
//  cs_pin     in   1       SPI chip select, active low
//  mosi_pin   in   1       SPI data in, MSB first
//  miso_pin   out  1       SPI data out, MSB first
//  miso_oe    out  1       high while slave drives miso (read data phase only)
//  leds       out  LED_W   low LED_W bits of last word written or read
//  frame_err  out  1       1-clk pulse: cs rose with partial command/word
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE.
//    - miso_pin=0, miso_oe=0, leds=0, frame_err=0; bit counter=0.
//    - Memory contents NOT cleared.
//  - Input sync: sclk_pin, cs_pin, mosi_pin pass through 2-FF synchronisers.
//    - sclk rise/fall are edge-detected on the synchronised value.
//    - Pin-to-event latency: 3 clk.
//    - Requirement: sclk high and low phases each >= 4 clk.
//  - Sampling: mosi is sampled on sclk rise.
//    - miso updates on sclk fall.
//    - sclk edges while cs high are ignored.
//  - Frame: cs fall -> CMD.
//    - Command = ADDR_W address bits (MSB first), then 1 R/W bit (1=read, 0=write).
//  - FSM:
//    - IDLE: on cs fall -> CMD.
//    - CMD: shift ADDR_W+1 bits; after last rise -> READ if R/W=1, else WRITE.
//    - WRITE: shift DATA_W bits.
//      - Clk after the DATA_W-th rise: mem[addr] <= word; leds <= word[LED_W-1:0].
//      - Then addr <= addr+1 (mod 2**ADDR_W); counter=0; stay in WRITE.
//    - READ: clk after entry: shift reg <= mem[addr]; addr <= addr+1; miso_oe=1.
//      - Each sclk fall presents the next bit; the first fall after the command presents the MSB.
//      - After DATA_W bits, shift reg reloads mem[addr] (already incremented); addr increments again.
//      - leds <= word[LED_W-1:0] at each load.
//    - any state: cs rise -> IDLE, miso_oe=0, miso_pin=0 within 3 clk.
//  - Abort: cs rise with bit counter != 0 in CMD or WRITE.
//    - Partial word discarded, no memory write.
//    - frame_err pulses 1 clk.
//    - cs rise in READ never flags.
//  - Wrap: address 2**ADDR_W-1 increments to 0 (both read and write bursts).
//  - Simultaneous: cs rise detected same clk as an sclk edge -> cs wins, edge ignored.
//  - reset_n low mid-frame: immediate IDLE.
//    - An in-progress word is not written; words completed earlier stay written.
// TESTING
//  - Reset: reset_n=0 during toggling pins -> miso_oe=0, leds=0, frame_err=0.
//  - Single write/read, defaults, clk 20ns, sclk 200ns:
//    - Write addr 0x2A data 0x5A.
//    - Then read 0x2A -> miso bits 0,1,0,1,1,0,1,0; leds=4'hA; miso_oe high only in data phase.
//  - Burst write at 0x7E of 0x11,0x22,0x33 (wrap):
//    - Read 0x7E burst x3 -> 0x11,0x22,0x33; mem[0x00]=0x33.
//  - Abort: write cmd to 0x10 + 5 data bits, cs high.
//    - frame_err one pulse; read 0x10 returns prior value.
//  - Reset mid-burst: after 2 of 3 burst words, reset_n=0 for 2 clk.
//    - Words 1-2 stored, word 3 not; FSM IDLE.
//  - Param: ADDR_W=4, DATA_W=16 -> write/read 0xBEEF at 0xF then burst wraps to 0x0 correctly.

Source files
------------

// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle between an SPI master (pad ring or bench) and spi_memory_burst.
// miso_oe lets the top level tri-state miso when the slave is not driving it.
interface spi_memory_burst_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin;
    logic miso_oe;

    modport master (
        output sclk_pin,
        output cs_pin,
        output mosi_pin,
        input  miso_pin,
        input  miso_oe
    );

    modport slave (
        input  sclk_pin,
        input  cs_pin,
        input  mosi_pin,
        output miso_pin,
        output miso_oe
    );
endinterface

// File: rtl/spi_memory_burst.sv
// Mode-0 SPI slave onto an on-chip register-file memory with auto-incrementing bursts.
// SPI pins are oversampled on clk; all events act three clk after the pin changes.
//
//   state | meaning
//   IDLE  | cs high or frame finished; sclk ignored
//   CMD   | shifting ADDR_W address bits then the R/W bit
//   WRITE | shifting data words in, each completed word written and address bumped
//   READ  | loading words from memory and shifting them out on sclk fall
module spi_memory_burst #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int LED_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_memory_burst_if.slave  spi,
    output logic [LED_W-1:0]   leds,
    output logic               frame_err
);
    localparam int DEPTH    = 2**ADDR_W;
    localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t state_q, state_d;

    logic [1:0]        sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic              sclk_prev_q, cs_prev_q;
    logic              sclk_s, cs_s, mosi_s;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              ld_pend_q, ld_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic              ferr_q, ferr_d;

    logic              addr_shift, cmd_done, wr_bit, rd_bit, do_load, abort;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // cs resets to "selected" so a frame already in progress at reset release
    // is not mistaken for a new cs fall; the FSM then waits for a clean frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi.sclk_pin};
            cs_sync_q   <= {cs_sync_q[0], spi.cs_pin};
            mosi_sync_q <= {mosi_sync_q[0], spi.mosi_pin};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    // Gating by cs also makes cs win over a coincident sclk edge.
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) state_d = CMD;
                end
                CMD: begin
                    if (sclk_rise && cnt_q == CMD_LAST) state_d = mosi_s ? READ : WRITE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_shift = 1'b0;
        cmd_done   = 1'b0;
        wr_bit     = 1'b0;
        rd_bit     = 1'b0;
        do_load    = 1'b0;
        abort      = 1'b0;
        case (state_q)
            CMD: begin
                addr_shift = sclk_rise & (cnt_q != CMD_LAST);
                cmd_done   = sclk_rise & (cnt_q == CMD_LAST);
                abort      = cs_rise & (cnt_q != '0);
            end
            WRITE: begin
                wr_bit = sclk_rise;
                abort  = cs_rise & (cnt_q != '0);
            end
            READ: begin
                do_load = ld_pend_q;
                rd_bit  = sclk_fall & ~ld_pend_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        leds_d    = leds_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        ld_pend_d = ld_pend_q;
        wr_pend_d = 1'b0;
        ferr_d    = abort;

        if (cs_fall) cnt_d = '0;

        if (addr_shift) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
            cnt_d  = cnt_q + CNT_W'(1);
        end

        if (cmd_done) begin
            cnt_d     = '0;
            ld_pend_d = mosi_s;
        end

        if (wr_bit) begin
            shift_d = {shift_q[DATA_W-2:0], mosi_s};
            if (cnt_q == DAT_LAST) begin
                cnt_d     = '0;
                wr_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (wr_pend_q) begin
            leds_d = shift_q[LED_W-1:0];
            addr_d = addr_q + ADDR_W'(1);
        end

        // Prefetch: the next word is loaded as soon as the previous one has gone out.
        if (do_load) begin
            shift_d   = mem_q[addr_q];
            leds_d    = mem_q[addr_q][LED_W-1:0];
            addr_d    = addr_q + ADDR_W'(1);
            oe_d      = 1'b1;
            ld_pend_d = 1'b0;
            cnt_d     = '0;
        end

        if (rd_bit) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (cnt_q == DAT_LAST) begin
                cnt_d     = '0;
                ld_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (cs_rise) begin
            cnt_d     = '0;
            ld_pend_d = 1'b0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            leds_q    <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            ld_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            leds_q    <= leds_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            ld_pend_q <= ld_pend_d;
            wr_pend_q <= wr_pend_d;
            ferr_q    <= ferr_d;
        end
    end

    // Memory survives reset; wr_pend_q is cleared asynchronously, so a word
    // still in flight when reset hits is never written.
    always_ff @(posedge clk) begin
        if (wr_pend_q) mem_q[addr_q] <= shift_q;
    end

    assign spi.miso_pin = miso_q;
    assign spi.miso_oe  = oe_q;
    assign leds         = leds_q;
    assign frame_err    = ferr_q;
endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: default-size instance A plus a 4-bit-address,
// 16-bit-data instance B, both checked against an array model of the memory.
module tb_spi_memory_burst;
    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    logic sclk, mosi, cs_a, cs_b;
    logic [3:0] leds_a, leds_b;
    logic ferr_a, ferr_b;

    spi_memory_burst_if ifa ();
    spi_memory_burst_if ifb ();

    assign ifa.sclk_pin = sclk;
    assign ifa.mosi_pin = mosi;
    assign ifa.cs_pin   = cs_a;
    assign ifb.sclk_pin = sclk;
    assign ifb.mosi_pin = mosi;
    assign ifb.cs_pin   = cs_b;

    spi_memory_burst dut_a (
        .clk(clk), .reset_n(reset_n), .spi(ifa), .leds(leds_a), .frame_err(ferr_a)
    );

    spi_memory_burst #(.ADDR_W(4), .DATA_W(16), .LED_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .spi(ifb), .leds(leds_b), .frame_err(ferr_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model
    logic [7:0]  mem_a [128];
    logic [15:0] mem_b [16];
    bit          kn_a [128];
    bit          kn_b [16];
    logic [3:0]  exp_leds_a, exp_leds_b;
    bit          lk_a, lk_b;
    int          exp_ferr_a = 0, exp_ferr_b = 0;
    int          fcnt_a = 0, fcnt_b = 0;

    logic        exp_oe, exp_bit, chk_on;
    bit          cur_sel;
    logic [15:0] wq [$];
    logic [15:0] rq [$];
    logic [3:0]  mid_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ferr_a === 1'b1) fcnt_a++;
        if (ferr_b === 1'b1) fcnt_b++;
    end

    // Master sampling instant: every sclk rise while a frame is active.
    always @(posedge sclk) begin
        if (chk_on) begin
            check("miso_oe", cur_sel ? ifb.miso_oe : ifa.miso_oe, exp_oe);
            check("other_oe", cur_sel ? ifa.miso_oe : ifb.miso_oe, 1'b0);
            if (exp_oe) check("miso_bit", cur_sel ? ifb.miso_pin : ifa.miso_pin, exp_bit);
        end
    end

    task automatic bit_xfer(input logic mo, input logic eoe, input logic eb, output logic samp);
        mosi    = mo;
        exp_oe  = eoe;
        exp_bit = eb;
        #100;
        samp = cur_sel ? ifb.miso_pin : ifa.miso_pin;
        sclk = 1'b1;
        #100;
        sclk = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_oe", ifa.miso_oe, 1'b0);
        check("rst_mid_leds", leds_a, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_leds_a = 4'h0;
        exp_leds_b = 4'h0;
        lk_a = 1'b1;
        lk_b = 1'b1;
    endtask

    // cut > 0: send only cut bits of the last word (abort).
    // rst_word >= 0: pulse reset_n before bit 4 of that word and abandon the frame.
    task automatic frame(input bit sel, input int addr, input bit rd, input int nwords,
                         input int cut, input int rst_word);
        int aw, dw, a, nb;
        logic [15:0] word, got;
        logic s;
        bit stop;
        aw = sel ? 4 : 7;
        dw = sel ? 16 : 8;
        stop = 1'b0;
        cur_sel = sel;
        rq.delete();
        exp_oe = 1'b0;
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        chk_on = 1'b1;
        #200;
        for (int i = aw - 1; i >= 0; i--) bit_xfer(addr[i], 1'b0, 1'b0, s);
        bit_xfer(rd, 1'b0, 1'b0, s);
        a = addr;
        for (int w = 0; w < nwords && !stop; w++) begin
            word = rd ? (sel ? mem_b[a] : {8'h00, mem_a[a]}) : wq[w];
            nb = (w == nwords - 1 && cut > 0) ? cut : dw;
            got = 16'h0;
            for (int b = 0; b < nb && !stop; b++) begin
                if (w == rst_word && b == 4) begin
                    do_reset();
                    stop = 1'b1;
                end else begin
                    if (rd && b == 4) begin
                        check("leds_rd", sel ? leds_b : leds_a, word[3:0]);
                        if (w == 0) mid_leds = sel ? leds_b : leds_a;
                    end
                    bit_xfer(rd ? 1'b0 : word[dw-1-b], rd, word[dw-1-b], s);
                    got = {got[14:0], s};
                end
            end
            if (!stop && nb == dw) begin
                if (rd) rq.push_back(got);
                else if (sel) begin mem_b[a] = word; kn_b[a] = 1'b1; end
                else begin mem_a[a] = word[7:0]; kn_a[a] = 1'b1; end
                if (sel) begin exp_leds_b = word[3:0]; lk_b = 1'b1; end
                else begin exp_leds_a = word[3:0]; lk_a = 1'b1; end
                a = (a + 1) % (1 << aw);
            end
        end
        if (rd && !stop) begin
            // the prefetch after the last word also updates leds
            if (sel) begin lk_b = kn_b[a]; if (kn_b[a]) exp_leds_b = mem_b[a][3:0]; end
            else begin lk_a = kn_a[a]; if (kn_a[a]) exp_leds_a = mem_a[a][3:0]; end
        end
        if (!rd && cut > 0 && !stop) begin
            if (sel) exp_ferr_b++; else exp_ferr_a++;
        end
        #100;
        chk_on = 1'b0;
        if (sel) cs_b = 1'b1; else cs_a = 1'b1;
        #200;
        check("oe_idle", sel ? ifb.miso_oe : ifa.miso_oe, 1'b0);
        check("miso_idle", sel ? ifb.miso_pin : ifa.miso_pin, 1'b0);
        if (sel ? lk_b : lk_a) check("leds_end", sel ? leds_b : leds_a, sel ? exp_leds_b : exp_leds_a);
        check("ferr_cnt_a", fcnt_a, exp_ferr_a);
        check("ferr_cnt_b", fcnt_b, exp_ferr_b);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1;
        sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
        chk_on = 1'b0; exp_oe = 1'b0; exp_bit = 1'b0; cur_sel = 1'b0;
        exp_leds_a = 4'h0; exp_leds_b = 4'h0; lk_a = 1'b1; lk_b = 1'b1;
        mid_leds = 4'h0;
        #20;
        reset_n = 1'b0;
        // pins wiggle while reset is held
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk; mosi = i[0]; cs_a = i[1]; cs_b = ~i[1];
            #100;
        end
        check("rst_oe_a", ifa.miso_oe, 1'b0);
        check("rst_miso_a", ifa.miso_pin, 1'b0);
        check("rst_leds_a", leds_a, 4'h0);
        check("rst_ferr_a", ferr_a, 1'b0);
        check("rst_oe_b", ifb.miso_oe, 1'b0);
        check("rst_leds_b", leds_b, 4'h0);
        check("rst_ferr_b", ferr_b, 1'b0);
        sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
        #200;
        reset_n = 1'b1;
        #200;

        // single write / read
        wq = '{16'h005A};
        frame(1'b0, 'h2A, 1'b0, 1, 0, -1);
        frame(1'b0, 'h2A, 1'b1, 1, 0, -1);
        check("rd_2a", rq[0], 16'h005A);
        check("leds_2a", mid_leds, 4'hA);

        // burst write across the top of memory, then read back
        wq = '{16'h0011, 16'h0022, 16'h0033};
        frame(1'b0, 'h7E, 1'b0, 3, 0, -1);
        frame(1'b0, 'h7E, 1'b1, 3, 0, -1);
        check("burst_w0", rq[0], 16'h0011);
        check("burst_w1", rq[1], 16'h0022);
        check("burst_w2", rq[2], 16'h0033);
        frame(1'b0, 'h00, 1'b1, 1, 0, -1);
        check("wrap_00", rq[0], 16'h0033);

        // aborted write keeps the old value
        wq = '{16'h00C3};
        frame(1'b0, 'h10, 1'b0, 1, 0, -1);
        wq = '{16'h00FF};
        frame(1'b0, 'h10, 1'b0, 1, 5, -1);
        check("abort_pulses", fcnt_a, 1);
        frame(1'b0, 'h10, 1'b1, 1, 0, -1);
        check("abort_keep", rq[0], 16'h00C3);

        // reset during the third word of a burst
        wq = '{16'h00EE};
        frame(1'b0, 'h42, 1'b0, 1, 0, -1);
        wq = '{16'h0001, 16'h0002, 16'h0003};
        frame(1'b0, 'h40, 1'b0, 3, 0, 2);
        check("rst_leds_clr", leds_a, 4'h0);
        frame(1'b0, 'h40, 1'b1, 3, 0, -1);
        check("rst_w0", rq[0], 16'h0001);
        check("rst_w1", rq[1], 16'h0002);
        check("rst_w2_kept", rq[2], 16'h00EE);

        // wide-data, narrow-address instance
        wq = '{16'hBEEF};
        frame(1'b1, 'hF, 1'b0, 1, 0, -1);
        frame(1'b1, 'hF, 1'b1, 1, 0, -1);
        check("b_rd_f", rq[0], 16'hBEEF);
        wq = '{16'hCAFE, 16'h1234};
        frame(1'b1, 'hF, 1'b0, 2, 0, -1);
        check("b_leds", leds_b, 4'h4);
        frame(1'b1, 'hF, 1'b1, 2, 0, -1);
        check("b_burst0", rq[0], 16'hCAFE);
        check("b_burst1", rq[1], 16'h1234);
        frame(1'b1, 'h0, 1'b1, 1, 0, -1);
        check("b_wrap_0", rq[0], 16'h1234);

        check("ferr_total_a", fcnt_a, 1);
        check("ferr_total_b", fcnt_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
